// File: rtl/spart_bus_arbiter.sv
// Two-master round-robin arbiter for the SPART register bus (iocs/iorw/ioaddr/databus).
// Supports lock for atomic multi-access sequences, a hold-time limit and a turnaround gap.
module spart_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic       m0_lock,
    input  logic       m0_iocs,
    input  logic       m0_iorw,
    input  logic [1:0] m0_ioaddr,
    input  logic [7:0] m0_wdata,
    output logic       m0_gnt,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_lock,
    input  logic       m1_iocs,
    input  logic       m1_iorw,
    input  logic [1:0] m1_ioaddr,
    input  logic [7:0] m1_wdata,
    output logic       m1_gnt,
    output logic [7:0] m1_rdata,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int unsigned GAP_W  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state;
    logic                owner;
    logic                last_owner;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [GAP_W-1:0]    gap_cnt;

    logic                own_st;
    logic                own_req;
    logic                own_lock;
    logic                other_req;
    logic                any_req;
    logic                pick;
    logic                release_now;
    logic                gap_last;
    logic                arb_now;
    logic                drive_en;
    logic [7:0]          own_wdata;

    // Arbitration and release decisions for the current cycle
    always_comb begin
        own_st    = (state == OWN);
        own_req   = owner ? m1_req  : m0_req;
        own_lock  = owner ? m1_lock : m0_lock;
        other_req = owner ? m0_req  : m1_req;
        any_req   = m0_req | m1_req;
        // Rotation only matters on a tie; otherwise the lone requester wins.
        pick      = (m0_req & m1_req) ? ~last_owner : m1_req;
        // >= so an owner whose counter saturated under lock is still forced off once it unlocks.
        release_now = (!own_req && !own_lock) ||
                      (!own_lock && other_req && (hold_cnt >= HOLD_W'(MAX_HOLD - 1)));
        gap_last  = (gap_cnt == GAP_W'(TURN_CYC - 1));
        arb_now   = (state == IDLE) || ((state == GAP) && gap_last);
    end

    // Register-bus mux: only the owner reaches the SPART, and only while in OWN
    always_comb begin
        iocs      = own_st & (owner ? m1_iocs : m0_iocs);
        iorw      = own_st ? (owner ? m1_iorw : m0_iorw) : 1'b1;
        ioaddr    = own_st ? (owner ? m1_ioaddr : m0_ioaddr) : 2'b00;
        own_wdata = owner ? m1_wdata : m0_wdata;
        drive_en  = own_st & iocs & ~iorw;
        m0_rdata  = (own_st && !owner && iorw) ? databus : 8'h00;
        m1_rdata  = (own_st &&  owner && iorw) ? databus : 8'h00;
    end

    assign databus = drive_en ? own_wdata : 8'hzz;

    // Arbiter state machine with registered grants
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
        end else begin
            case (state)
                OWN: begin
                    if (hold_cnt != HOLD_W'(MAX_HOLD))
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (release_now) begin
                        state      <= GAP;
                        gap_cnt    <= '0;
                        last_owner <= owner;
                        m0_gnt     <= 1'b0;
                        m1_gnt     <= 1'b0;
                    end
                end
                GAP: begin
                    if (!gap_last)
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    else if (!any_req)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Grant issue, from IDLE or the last turnaround cycle
            if (arb_now && any_req) begin
                state    <= OWN;
                owner    <= pick;
                hold_cnt <= '0;
                m0_gnt   <= ~pick;
                m1_gnt   <= pick;
            end
        end
    end

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed testbench for spart_bus_arbiter: reset, tie rotation, lock, forced release,
// read path and mid-transfer reset.
module tb_spart_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       m0_req, m0_lock, m0_iocs, m0_iorw;
    logic [1:0] m0_ioaddr;
    logic [7:0] m0_wdata;
    logic       m0_gnt;
    logic [7:0] m0_rdata;
    logic       m1_req, m1_lock, m1_iocs, m1_iorw;
    logic [1:0] m1_ioaddr;
    logic [7:0] m1_wdata;
    logic       m1_gnt;
    logic [7:0] m1_rdata;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       spart_en;
    logic [7:0] spart_drv;

    int errors = 0;
    int checks = 0;

    assign databus = spart_en ? spart_drv : 8'hzz;

    spart_bus_arbiter #(.MAX_HOLD(16), .TURN_CYC(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_lock   (m0_lock),
        .m0_iocs   (m0_iocs),
        .m0_iorw   (m0_iorw),
        .m0_ioaddr (m0_ioaddr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_lock   (m1_lock),
        .m1_iocs   (m1_iocs),
        .m1_iorw   (m1_iorw),
        .m1_ioaddr (m1_ioaddr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rdata  (m1_rdata),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        m0_iocs = 1'b1; m0_iorw = 1'b0; m0_ioaddr = 2'b11;
        tick();
        tick();
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt});
        end
        checks++;
        if ({iocs, iorw, ioaddr} !== 4'b0100) begin
            errors++; $display("FAIL reset_bus: got iocs=%b iorw=%b ioaddr=%b want 0 1 00", iocs, iorw, ioaddr);
        end
        checks++;
        if (!(databus === 8'hzz || databus === 8'h00)) begin
            errors++; $display("FAIL reset_databus: got %h want released", databus);
        end
        m0_iocs = 1'b0; m0_iorw = 1'b1; m0_ioaddr = 2'b00;
    endtask

    task automatic test_tie();
        rst = 1'b1;
        tick();
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            errors++; $display("FAIL tie_first_m0: got %b want 10", {m0_gnt, m1_gnt});
        end
        m0_req = 1'b0;
        tick();
        checks++;
        if ({m0_gnt, m1_gnt, iocs, iorw} !== 4'b0001) begin
            errors++; $display("FAIL tie_gap: got gnt=%b iocs=%b iorw=%b want 00 0 1", {m0_gnt, m1_gnt}, iocs, iorw);
        end
        tick();
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            errors++; $display("FAIL tie_then_m1: got %b want 01", {m0_gnt, m1_gnt});
        end
        m1_req = 1'b0;
        tick();
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            errors++; $display("FAIL tie_repeat_m0: got %b want 10", {m0_gnt, m1_gnt});
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_lock();
        int lost;
        m0_req = 1'b1; m0_lock = 1'b1;
        tick();
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            errors++; $display("FAIL lock_grant: got %b want 10", {m0_gnt, m1_gnt});
        end
        m1_req = 1'b1;
        m0_iocs = 1'b1; m0_iorw = 1'b0; m0_ioaddr = 2'b10; m0_wdata = 8'h8A;
        #1;
        checks++;
        if ({iocs, iorw, ioaddr, databus} !== {1'b1, 1'b0, 2'b10, 8'h8A}) begin
            errors++; $display("FAIL lock_wr_lo: got iocs=%b iorw=%b addr=%b data=%h want 1 0 10 8a", iocs, iorw, ioaddr, databus);
        end
        tick();
        m0_ioaddr = 2'b11; m0_wdata = 8'h02;
        #1;
        checks++;
        if ({iocs, iorw, ioaddr, databus} !== {1'b1, 1'b0, 2'b11, 8'h02}) begin
            errors++; $display("FAIL lock_wr_hi: got iocs=%b iorw=%b addr=%b data=%h want 1 0 11 02", iocs, iorw, ioaddr, databus);
        end
        tick();
        m0_iocs = 1'b0; m0_iorw = 1'b1; m0_wdata = 8'h3C;
        lost = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) m0_req = 1'b0;
            tick();
            if ({m0_gnt, m1_gnt} !== 2'b10) lost++;
        end
        checks++;
        if (lost !== 0) begin
            errors++; $display("FAIL lock_hold: got %0d cycles without M0 grant want 0", lost);
        end
        m0_lock = 1'b0;
        tick();
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            errors++; $display("FAIL lock_gap: got %b want 00", {m0_gnt, m1_gnt});
        end
        tick();
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            errors++; $display("FAIL lock_m1_after: got %b want 01", {m0_gnt, m1_gnt});
        end
    endtask

    task automatic test_forced_release();
        int held;
        m1_req = 1'b0;
        tick();
        m0_req = 1'b1; m0_lock = 1'b0; m1_req = 1'b1;
        tick();
        held = 0;
        for (int i = 0; i < 40; i++) begin
            if (m0_gnt !== 1'b1) break;
            held++;
            tick();
        end
        checks++;
        if (held !== 16) begin
            errors++; $display("FAIL forced_hold: got %0d cycles want 16", held);
        end
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            errors++; $display("FAIL forced_gap: got %b want 00", {m0_gnt, m1_gnt});
        end
        tick();
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            errors++; $display("FAIL forced_m1: got %b want 01", {m0_gnt, m1_gnt});
        end
        m0_req = 1'b0;
    endtask

    task automatic test_read();
        m1_iocs = 1'b1; m1_iorw = 1'b1; m1_ioaddr = 2'b00; m1_wdata = 8'hC3;
        m0_iocs = 1'b1; m0_iorw = 1'b0; m0_wdata = 8'h3C;
        spart_drv = 8'h5A; spart_en = 1'b1;
        #1;
        checks++;
        if (m1_rdata !== 8'h5A) begin
            errors++; $display("FAIL read_m1_rdata: got %h want 5a", m1_rdata);
        end
        checks++;
        if (m0_rdata !== 8'h00) begin
            errors++; $display("FAIL read_m0_rdata: got %h want 00", m0_rdata);
        end
        checks++;
        if ({iocs, iorw, ioaddr, databus} !== {1'b1, 1'b1, 2'b00, 8'h5A}) begin
            errors++; $display("FAIL read_bus: got iocs=%b iorw=%b addr=%b data=%h want 1 1 00 5a", iocs, iorw, ioaddr, databus);
        end
        spart_en = 1'b0;
        #1;
        checks++;
        if (!(databus === 8'hzz || databus === 8'h00)) begin
            errors++; $display("FAIL read_no_drive: got %h want released", databus);
        end
        m0_iocs = 1'b0; m0_iorw = 1'b1;
        tick();
    endtask

    task automatic test_midop_reset();
        m1_iorw = 1'b0; m1_iocs = 1'b1; m1_ioaddr = 2'b01; m1_wdata = 8'hC3;
        #1;
        checks++;
        if (databus !== 8'hC3) begin
            errors++; $display("FAIL midop_write: got %h want c3", databus);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({m0_gnt, m1_gnt, iocs} !== 3'b000) begin
            errors++; $display("FAIL midop_gnt: got gnt=%b iocs=%b want 00 0", {m0_gnt, m1_gnt}, iocs);
        end
        checks++;
        if (!(databus === 8'hzz || databus === 8'h00)) begin
            errors++; $display("FAIL midop_databus: got %h want released", databus);
        end
        rst = 1'b1;
        m1_iocs = 1'b0; m1_iorw = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            errors++; $display("FAIL midop_tie_m0: got %b want 10", {m0_gnt, m1_gnt});
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        m0_req = 1'b0; m0_lock = 1'b0; m0_iocs = 1'b0; m0_iorw = 1'b1;
        m0_ioaddr = 2'b00; m0_wdata = 8'h3C;
        m1_req = 1'b0; m1_lock = 1'b0; m1_iocs = 1'b0; m1_iorw = 1'b1;
        m1_ioaddr = 2'b00; m1_wdata = 8'hC3;
        spart_en = 1'b0; spart_drv = 8'h00;
        test_reset();
        test_tie();
        test_lock();
        test_forced_release();
        test_read();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
